// File: rtl/core_pkg.sv
// Shared constants and MEM-stage state encoding for the 5-stage MIPS core.
package core_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DADDR_W    = 30;

  typedef logic [1:0] mem_state_t;

  localparam mem_state_t MEM_IDLE = 2'd0;
  localparam mem_state_t MEM_WAIT = 2'd1;
  localparam mem_state_t MEM_DONE = 2'd2;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register bank: loads when enabled, holds otherwise, sync reset to zero.
module mem_wb_reg #(
  parameter int unsigned DATA_W     = core_pkg::DATA_W,
  parameter int unsigned REG_ADDR_W = core_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic                  i_mem_to_reg,
  input  logic                  i_reg_write,
  input  logic [REG_ADDR_W-1:0] i_write_reg,
  input  logic [DATA_W-1:0]     i_alu_result,
  input  logic [DATA_W-1:0]     i_mem_data,
  output logic                  o_mem_to_reg,
  output logic                  o_reg_write,
  output logic [REG_ADDR_W-1:0] o_write_reg,
  output logic [DATA_W-1:0]     o_alu_result,
  output logic [DATA_W-1:0]     o_mem_data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      o_mem_to_reg <= 1'b0;
      o_reg_write  <= 1'b0;
      o_write_reg  <= '0;
      o_alu_result <= '0;
      o_mem_data   <= '0;
    end else if (i_en) begin
      o_mem_to_reg <= i_mem_to_reg;
      o_reg_write  <= i_reg_write;
      o_write_reg  <= i_write_reg;
      o_alu_result <= i_alu_result;
      o_mem_data   <= i_mem_data;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: issues D-cache requests, tracks completion across stalls,
// and feeds the MEM/WB register.
module mem_access_stage #(
  parameter int unsigned DATA_W     = core_pkg::DATA_W,
  parameter int unsigned REG_ADDR_W = core_pkg::REG_ADDR_W,
  parameter int unsigned DADDR_W    = core_pkg::DADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemRead_MEM,
  input  logic                  MemWrite_MEM,
  input  logic                  MemToReg_MEM,
  input  logic                  RegWrite_MEM,
  input  logic [REG_ADDR_W-1:0] WriteReg_MEM,
  input  logic [DATA_W-1:0]     ALU_result_MEM,
  input  logic [DATA_W-1:0]     WriteData_MEM,
  input  logic                  Stall_in,
  output logic                  DCACHE_ren,
  output logic                  DCACHE_wen,
  output logic [DADDR_W-1:0]    DCACHE_addr,
  output logic [DATA_W-1:0]     DCACHE_wdata,
  input  logic [DATA_W-1:0]     DCACHE_rdata,
  input  logic                  DCACHE_stall,
  output logic                  Stall_MEM,
  output logic                  MemToReg_WB,
  output logic                  RegWrite_WB,
  output logic [REG_ADDR_W-1:0] WriteReg_WB,
  output logic [DATA_W-1:0]     ALU_result_WB,
  output logic [DATA_W-1:0]     Mem_Data_WB
);

  import core_pkg::*;

  mem_state_t        r_state;
  mem_state_t        w_state_next;
  logic [DATA_W-1:0] r_hold_data;
  logic              w_capture;
  logic              w_access;
  logic              w_not_done;
  logic              w_wb_en;
  logic [DATA_W-1:0] w_mem_data;
  logic [1:0]        w_unused_addr_lsb;

  assign w_access   = MemRead_MEM | MemWrite_MEM;
  assign w_not_done = (r_state != MEM_DONE);

  // DONE means the access already finished; re-requesting would repeat a store.
  assign DCACHE_ren   = MemRead_MEM & w_not_done & ~rst;
  assign DCACHE_wen   = MemWrite_MEM & ~MemRead_MEM & w_not_done & ~rst;
  assign DCACHE_addr  = ALU_result_MEM[DADDR_W+1:2];
  assign DCACHE_wdata = WriteData_MEM;

  assign w_unused_addr_lsb = ALU_result_MEM[1:0];

  assign Stall_MEM = w_access & DCACHE_stall & w_not_done;
  assign w_wb_en   = ~Stall_MEM & ~Stall_in;

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    case (r_state)
      MEM_IDLE: begin
        if (w_access && DCACHE_stall) begin
          w_state_next = MEM_WAIT;
        end else if (w_access && Stall_in) begin
          w_state_next = MEM_DONE;
          w_capture    = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (w_access && !DCACHE_stall && Stall_in) begin
          w_state_next = MEM_DONE;
          w_capture    = 1'b1;
        end else if (!DCACHE_stall && !Stall_in) begin
          w_state_next = MEM_IDLE;
        end
      end
      MEM_DONE: begin
        if (!Stall_in) w_state_next = MEM_IDLE;
      end
      default: w_state_next = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= MEM_IDLE;
      r_hold_data <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_capture) r_hold_data <= DCACHE_rdata;
    end
  end

  always_comb begin
    w_mem_data = '0;
    if (MemRead_MEM) w_mem_data = (r_state == MEM_DONE) ? r_hold_data : DCACHE_rdata;
  end

  mem_wb_reg #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_mem_wb_reg (
    .clk          (clk),
    .rst          (rst),
    .i_en         (w_wb_en),
    .i_mem_to_reg (MemToReg_MEM),
    .i_reg_write  (RegWrite_MEM),
    .i_write_reg  (WriteReg_MEM),
    .i_alu_result (ALU_result_MEM),
    .i_mem_data   (w_mem_data),
    .o_mem_to_reg (MemToReg_WB),
    .o_reg_write  (RegWrite_WB),
    .o_write_reg  (WriteReg_WB),
    .o_alu_result (ALU_result_WB),
    .o_mem_data   (Mem_Data_WB)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: expected MEM/WB contents are queued per cycle
// and checked by an independent monitor; request/stall outputs are checked inline.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead_MEM, MemWrite_MEM, MemToReg_MEM, RegWrite_MEM;
  logic [4:0]  WriteReg_MEM;
  logic [31:0] ALU_result_MEM, WriteData_MEM;
  logic        Stall_in;
  logic        DCACHE_ren, DCACHE_wen;
  logic [29:0] DCACHE_addr;
  logic [31:0] DCACHE_wdata, DCACHE_rdata;
  logic        DCACHE_stall;
  logic        Stall_MEM;
  logic        MemToReg_WB, RegWrite_WB;
  logic [4:0]  WriteReg_WB;
  logic [31:0] ALU_result_WB, Mem_Data_WB;

  mem_access_stage dut (
    .clk            (clk),
    .rst            (rst),
    .MemRead_MEM    (MemRead_MEM),
    .MemWrite_MEM   (MemWrite_MEM),
    .MemToReg_MEM   (MemToReg_MEM),
    .RegWrite_MEM   (RegWrite_MEM),
    .WriteReg_MEM   (WriteReg_MEM),
    .ALU_result_MEM (ALU_result_MEM),
    .WriteData_MEM  (WriteData_MEM),
    .Stall_in       (Stall_in),
    .DCACHE_ren     (DCACHE_ren),
    .DCACHE_wen     (DCACHE_wen),
    .DCACHE_addr    (DCACHE_addr),
    .DCACHE_wdata   (DCACHE_wdata),
    .DCACHE_rdata   (DCACHE_rdata),
    .DCACHE_stall   (DCACHE_stall),
    .Stall_MEM      (Stall_MEM),
    .MemToReg_WB    (MemToReg_WB),
    .RegWrite_WB    (RegWrite_WB),
    .WriteReg_WB    (WriteReg_WB),
    .ALU_result_WB  (ALU_result_WB),
    .Mem_Data_WB    (Mem_Data_WB)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        m2r;
    logic        rw;
    logic [4:0]  wr;
    logic [31:0] alu;
    logic [31:0] md;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, req);
    end
  endtask

  // Queue the WB contents expected once the next edge has happened.
  task automatic expect_wb(input logic m2r, input logic rw, input logic [4:0] wr,
                           input logic [31:0] alu, input logic [31:0] md);
    exp_t e;
    e.cyc = cyc + 1;
    e.m2r = m2r;
    e.rw  = rw;
    e.wr  = wr;
    e.alu = alu;
    e.md  = md;
    sb.push_back(e);
    last = e;
  endtask

  task automatic expect_hold();
    expect_wb(last.m2r, last.rw, last.wr, last.alu, last.md);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic rd, input logic wr_en, input logic m2r, input logic rw,
                        input logic [4:0] wreg, input logic [31:0] alu);
    MemRead_MEM    = rd;
    MemWrite_MEM   = wr_en;
    MemToReg_MEM   = m2r;
    RegWrite_MEM   = rw;
    WriteReg_MEM   = wreg;
    ALU_result_MEM = alu;
  endtask

  // Monitor: compares the WB bank against the scoreboard head for the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      exp_t m;
      m = sb.pop_front();
      chk("wb_missed_slot", 32'(m.cyc), 32'(cyc));
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      exp_t e;
      e = sb.pop_front();
      chk("MemToReg_WB", 32'(MemToReg_WB), 32'(e.m2r));
      chk("RegWrite_WB", 32'(RegWrite_WB), 32'(e.rw));
      chk("WriteReg_WB", 32'(WriteReg_WB), 32'(e.wr));
      chk("ALU_result_WB", ALU_result_WB, e.alu);
      chk("Mem_Data_WB", Mem_Data_WB, e.md);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    last = '{0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0};
    rst = 1'b1;
    set_op(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    WriteData_MEM = 32'd0;
    Stall_in      = 1'b0;
    DCACHE_rdata  = 32'd0;
    DCACHE_stall  = 1'b0;

    // Reset with a load presented: no request, WB cleared.
    tick();
    chk("rst_ren", 32'(DCACHE_ren), 32'd0);
    expect_wb(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    tick();
    chk("rst_ren2", 32'(DCACHE_ren), 32'd0);
    chk("rst_state", 32'(dut.r_state), 32'd0);

    // Load hit.
    rst = 1'b0;
    set_op(1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 32'h0000_0010);
    DCACHE_rdata = 32'hDEAD_BEEF;
    #1;
    chk("hit_addr", 32'(DCACHE_addr), 32'h4);
    chk("hit_ren", 32'(DCACHE_ren), 32'd1);
    chk("hit_wen", 32'(DCACHE_wen), 32'd0);
    chk("hit_stall_mem", 32'(Stall_MEM), 32'd0);
    expect_wb(1'b1, 1'b1, 5'd3, 32'h10, 32'hDEAD_BEEF);
    tick();

    // Load miss, 3 stall cycles.
    set_op(1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 32'h0000_0020);
    DCACHE_rdata = 32'd0;
    DCACHE_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("miss_stall_mem", 32'(Stall_MEM), 32'd1);
      chk("miss_ren", 32'(DCACHE_ren), 32'd1);
      expect_hold();
      tick();
    end
    DCACHE_stall = 1'b0;
    DCACHE_rdata = 32'h0000_1234;
    #1;
    chk("miss_end_stall_mem", 32'(Stall_MEM), 32'd0);
    chk("miss_end_ren", 32'(DCACHE_ren), 32'd1);
    expect_wb(1'b1, 1'b1, 5'd4, 32'h20, 32'h1234);
    tick();

    // Store completing while the pipeline is frozen.
    set_op(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0000_0040);
    WriteData_MEM = 32'h0000_CAFE;
    Stall_in = 1'b1;
    #1;
    chk("st_wen", 32'(DCACHE_wen), 32'd1);
    chk("st_ren", 32'(DCACHE_ren), 32'd0);
    chk("st_wdata", DCACHE_wdata, 32'h0000_CAFE);
    chk("st_stall_mem", 32'(Stall_MEM), 32'd0);
    expect_hold();
    tick();
    chk("st_done_wen", 32'(DCACHE_wen), 32'd0);
    chk("st_done_state", 32'(dut.r_state), 32'd2);
    expect_hold();
    tick();
    Stall_in = 1'b0;
    #1;
    chk("st_release_wen", 32'(DCACHE_wen), 32'd0);
    expect_wb(1'b0, 1'b0, 5'd0, 32'h40, 32'd0);
    tick();

    // Load completing while frozen; data changes afterwards.
    set_op(1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 32'h0000_0080);
    DCACHE_rdata = 32'h0000_A5A5;
    Stall_in = 1'b1;
    #1;
    chk("ldf_ren", 32'(DCACHE_ren), 32'd1);
    expect_hold();
    tick();
    DCACHE_rdata = 32'h0000_FFFF;
    #1;
    chk("ldf_done_ren", 32'(DCACHE_ren), 32'd0);
    expect_hold();
    tick();
    Stall_in = 1'b0;
    expect_wb(1'b1, 1'b1, 5'd9, 32'h80, 32'h0000_A5A5);
    tick();

    // Miss under freeze: Stall_MEM ignores Stall_in; completion lands in DONE.
    set_op(1'b1, 1'b0, 1'b1, 1'b1, 5'd10, 32'h0000_0100);
    DCACHE_rdata = 32'h55;
    DCACHE_stall = 1'b1;
    Stall_in = 1'b1;
    #1;
    chk("mf_stall_mem", 32'(Stall_MEM), 32'd1);
    expect_hold();
    tick();
    DCACHE_stall = 1'b0;
    DCACHE_rdata = 32'h77;
    #1;
    chk("mf_end_stall_mem", 32'(Stall_MEM), 32'd0);
    chk("mf_end_ren", 32'(DCACHE_ren), 32'd1);
    expect_hold();
    tick();
    DCACHE_rdata = 32'h99;
    Stall_in = 1'b0;
    #1;
    chk("mf_done_ren", 32'(DCACHE_ren), 32'd0);
    expect_wb(1'b1, 1'b1, 5'd10, 32'h100, 32'h77);
    tick();

    // ALU op, then held by Stall_in without a bubble.
    set_op(1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 32'd42);
    DCACHE_rdata = 32'hBAD0_BAD0;
    #1;
    chk("alu_ren", 32'(DCACHE_ren), 32'd0);
    chk("alu_wen", 32'(DCACHE_wen), 32'd0);
    chk("alu_stall_mem", 32'(Stall_MEM), 32'd0);
    expect_wb(1'b0, 1'b1, 5'd7, 32'd42, 32'd0);
    tick();
    ALU_result_MEM = 32'd43;
    Stall_in = 1'b1;
    expect_hold();
    tick();
    Stall_in = 1'b0;
    expect_wb(1'b0, 1'b1, 5'd7, 32'd43, 32'd0);
    tick();

    // Read and write together: treated as a load.
    set_op(1'b1, 1'b1, 1'b1, 1'b1, 5'd2, 32'h0000_0008);
    DCACHE_rdata = 32'h0000_0BB0;
    #1;
    chk("rw_ren", 32'(DCACHE_ren), 32'd1);
    chk("rw_wen", 32'(DCACHE_wen), 32'd0);
    expect_wb(1'b1, 1'b1, 5'd2, 32'h8, 32'h0BB0);
    tick();

    // Reset while in WAIT abandons the access.
    set_op(1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 32'h0000_0200);
    DCACHE_stall = 1'b1;
    expect_hold();
    tick();
    rst = 1'b1;
    #1;
    chk("rstw_ren", 32'(DCACHE_ren), 32'd0);
    expect_wb(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    tick();
    rst = 1'b0;
    set_op(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    DCACHE_stall = 1'b0;
    #1;
    chk("rstw_state", 32'(dut.r_state), 32'd0);
    tick();
    tick();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
